// File: rtl/register_file_pkg.sv
// Shared types for the register bank: write-port operation encoding.
package register_file_pkg;

   typedef enum logic [1:0] {
      RF_LOAD = 2'b00,
      RF_ADD  = 2'b01,
      RF_SHL  = 2'b10,
      RF_CLR  = 2'b11
   } rf_op_t;

endpackage

// File: rtl/register_file_rf_alu.sv
// Write-port operation unit: computes the post-op register value and carry
// for the addressed register, purely combinational.
module rf_alu
   import register_file_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 11,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic [DATA_WIDTH-1:0] r,
   input  logic [DATA_WIDTH-1:0] d,
   input  rf_op_t                op,
   output logic [DATA_WIDTH-1:0] next_r,
   output logic                  next_carry,
   output logic                  carry_en
);

   logic [DATA_WIDTH:0] sum;

   assign sum = {1'b0, r} + {1'b0, d};

   always_comb begin
      next_r     = r;
      next_carry = 1'b0;
      carry_en   = 1'b0;
      case (op)
         RF_LOAD: next_r = d;
         RF_ADD: begin
            next_r     = sum[DATA_WIDTH-1:0];
            next_carry = sum[DATA_WIDTH];
            carry_en   = 1'b1;
         end
         RF_SHL: begin
            next_r     = {r[DATA_WIDTH-2:0], 1'b0};
            next_carry = r[DATA_WIDTH-1];
            carry_en   = 1'b1;
         end
         RF_CLR: next_r = RESET_VALUE;
         default: next_r = r;
      endcase
   end

endmodule

// File: rtl/register_file.sv
// Datapath register bank: one read-modify-write port, two registered read
// ports with write-first bypass, per-register valid bits and a carry flag.
module register_file
   import register_file_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 11,
   parameter int                    REG_COUNT   = 8,
   parameter int                    ADDR_WIDTH  = $clog2(REG_COUNT),
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  rf_reset_n,
   input  logic                  rf_clear,
   input  logic                  rf_wr,
   input  logic [1:0]            rf_op,
   input  logic [ADDR_WIDTH-1:0] rf_wr_addr,
   input  logic [DATA_WIDTH-1:0] rf_wr_data,
   input  logic [ADDR_WIDTH-1:0] rf_rd_addr_a,
   output logic [DATA_WIDTH-1:0] rf_rd_data_a,
   input  logic [ADDR_WIDTH-1:0] rf_rd_addr_b,
   output logic [DATA_WIDTH-1:0] rf_rd_data_b,
   output logic [REG_COUNT-1:0]  rf_valid,
   output logic                  rf_carry
);

   localparam logic [ADDR_WIDTH:0] REG_LIMIT = REG_COUNT[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] regs      [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_next [REG_COUNT];
   logic [REG_COUNT-1:0]  valid_next;
   logic                  carry_next;
   logic [DATA_WIDTH-1:0] rd_a_next;
   logic [DATA_WIDTH-1:0] rd_b_next;
   logic                  wr_hit;
   logic [DATA_WIDTH-1:0] cur_r;
   logic [DATA_WIDTH-1:0] alu_r;
   logic                  alu_carry;
   logic                  alu_carry_en;
   rf_op_t                op;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < REG_LIMIT;
   endfunction

   assign op = rf_op_t'(rf_op);

   always_comb begin
      wr_hit = rf_wr && in_range(rf_wr_addr);
      cur_r  = RESET_VALUE;
      if (wr_hit)
         cur_r = regs[rf_wr_addr];
   end

   rf_alu #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_alu (
      .r          (cur_r),
      .d          (rf_wr_data),
      .op         (op),
      .next_r     (alu_r),
      .next_carry (alu_carry),
      .carry_en   (alu_carry_en)
   );

   // Clear wins over the write port; reads see the post-write bank (bypass).
   always_comb begin
      regs_next  = regs;
      valid_next = rf_valid;
      carry_next = rf_carry;
      if (rf_clear) begin
         for (int i = 0; i < REG_COUNT; i++)
            regs_next[i] = RESET_VALUE;
         valid_next = '0;
         carry_next = 1'b0;
      end else if (wr_hit) begin
         regs_next[rf_wr_addr]  = alu_r;
         valid_next[rf_wr_addr] = (op != RF_CLR);
         if (alu_carry_en)
            carry_next = alu_carry;
      end
   end

   always_comb begin
      rd_a_next = RESET_VALUE;
      rd_b_next = RESET_VALUE;
      if (in_range(rf_rd_addr_a))
         rd_a_next = regs_next[rf_rd_addr_a];
      if (in_range(rf_rd_addr_b))
         rd_b_next = regs_next[rf_rd_addr_b];
   end

   always_ff @(posedge clock or negedge rf_reset_n) begin
      if (!rf_reset_n) begin
         for (int i = 0; i < REG_COUNT; i++)
            regs[i] <= RESET_VALUE;
         rf_valid     <= '0;
         rf_carry     <= 1'b0;
         rf_rd_data_a <= RESET_VALUE;
         rf_rd_data_b <= RESET_VALUE;
      end else begin
         regs         <= regs_next;
         rf_valid     <= valid_next;
         rf_carry     <= carry_next;
         rf_rd_data_a <= rd_a_next;
         rf_rd_data_b <= rd_b_next;
      end
   end

endmodule
